// File: rtl/fetch_pkg.sv
// Shared types, constants and instruction-field helpers for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    HALT   = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [5:0]  HALT_OP          = 6'b111111;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int TGT_MSB   = 25;
  localparam int TGT_LSB   = 0;

  // Word offset of a taken branch: sign-extended immediate scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  function automatic logic [31:0] jump_target(input logic [3:0] pc_hi, input logic [25:0] tgt);
    return {pc_hi, tgt, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/next_pc_sel.sv
// Next-PC selection: Jump has priority over a taken branch, otherwise sequential.
module next_pc_sel
  import fetch_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  output logic [31:0] next_pc
);

  logic unused_op_s;
  assign unused_op_s = ^instr[OP_MSB:OP_LSB];

  // Priority select of the following PC.
  always_comb begin
    next_pc = pc_plus4;
    if (Jump) begin
      next_pc = jump_target(pc_plus4[31:28], instr[TGT_MSB:TGT_LSB]);
    end else if (Branch && Zero) begin
      next_pc = pc_plus4 + branch_offset(instr[IMM_MSB:IMM_LSB]);
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch unit: FETCH -> DECODE -> FETCH, one instruction per >=2 cycles.
// Optional halt opcode support is enabled with the FETCH_HALT_EN macro.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_fetch_if.master        imem,
  input  logic                 stall,
  input  logic                 Branch,
  input  logic                 Zero,
  input  logic                 Jump,
  output logic [31:0]          instr,
  output logic [5:0]           OP,
  output logic [5:0]           Funct,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic                 instr_valid,
  output logic                 halted
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_plus4_s;
  logic [31:0]  next_pc_s;
  logic         imem_req_s;
  logic         instr_valid_s;
  logic         halted_s;

  assign pc_plus4_s = pc_q + 32'd4;

  next_pc_sel u_next_pc_sel (
    .pc_plus4 (pc_plus4_s),
    .instr    (instr_q),
    .Branch   (Branch),
    .Zero     (Zero),
    .Jump     (Jump),
    .next_pc  (next_pc_s)
  );

  // Next-state and output decode; outputs are forced low while reset is held.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    imem_req_s    = 1'b0;
    instr_valid_s = 1'b0;
    halted_s      = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req_s = !reset;
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        instr_valid_s = !reset;
        if (!stall) begin
`ifdef FETCH_HALT_EN
          if (instr_q[OP_MSB:OP_LSB] == HALT_OP) begin
            state_d = HALT;
          end else begin
            pc_d    = next_pc_s;
            state_d = FETCH;
          end
`else
          pc_d    = next_pc_s;
          state_d = FETCH;
`endif
        end else begin
          state_d = DECODE;
        end
      end
      HALT: begin
`ifdef FETCH_HALT_EN
        halted_s = !reset;
`else
        state_d = FETCH;
`endif
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State registers with synchronous reset overriding all other inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem.imem_req  = imem_req_s;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign OP             = instr_q[OP_MSB:OP_LSB];
  assign Funct          = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign pc             = pc_q;
  assign pc_plus4       = pc_plus4_s;
  assign instr_valid    = instr_valid_s;
  assign halted         = halted_s;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port: imem_addr  output  32  word-aligned fetch address (= pc).
REQ-006 SHALL have port: imem_ack  input  1  read data valid this cycle.
REQ-007 SHALL have port: imem_rdata  input  32  instruction word from memory.
REQ-008 SHALL have port: stall  input  1  downstream not ready to consume the held instruction.
REQ-009 SHALL have port: Branch  input  1  branch decode from the control unit.
REQ-010 SHALL have port: Zero  input  1  ALU zero flag for the held instruction.
REQ-011 SHALL have port: Jump  input  1  jump decode from the control unit.
REQ-012 SHALL have port: instr  output  32  held instruction word.
REQ-013 SHALL have port: OP  output  6  instr[31:26], fed to the control unit.
REQ-014 SHALL have port: Funct  output  6  instr[5:0], fed to the control unit.
REQ-015 SHALL have port: pc  output  32  address of the held or in-flight instruction.
REQ-016 SHALL have port: pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-017 SHALL have port: instr_valid  output  1  instr/OP/Funct valid for decode.
REQ-018 SHALL have port: halted  output  1  fetch frozen by halt opcode.

Function
REQ-019 SHALL implement states FETCH, DECODE, HALT.
REQ-020 FETCH: imem_req=1, imem_addr=pc held stable until imem_ack; on ack, instr<=imem_rdata and next state DECODE.
REQ-021 DECODE: instr_valid=1, imem_req=0; while stall=1, remain in DECODE with instr and pc unchanged.
REQ-022 DECODE with stall=0: pc<=next PC and next state FETCH, for 1 instruction per >=2 cycles.
REQ-023 Next PC priority: Jump -> {pc_plus4[31:28], instr[25:0], 2'b00}; else Branch&Zero -> pc_plus4 + (sign-extended instr[15:0] << 2); else pc_plus4.
REQ-024 Jump and Branch&Zero asserted together: Jump SHALL win.
REQ-025 Branch, Zero and Jump SHALL be ignored outside DECODE and while stall=1.
REQ-026 All PC arithmetic 32-bit and wraps: pc 32'hFFFF_FFFC plus 4 gives 32'h0000_0000.
REQ-027 imem_ack outside FETCH SHALL be ignored with no state change.
REQ-028 OP and Funct SHALL be combinational slices of the instr register.

Reset
REQ-029 reset=1 at an edge: pc<=RESET_PC, instr<=0, state<=FETCH; reset overrides every other input.
REQ-030 While reset=1: imem_req=0, instr_valid=0, halted=0; imem_req rises the first cycle after reset deasserts.
REQ-031 Reset mid-request or mid-stall SHALL discard the outstanding fetch; a late imem_ack SHALL be ignored unless it coincides with the new FETCH.

Configuration
REQ-032 Macro FETCH_HALT_EN defined: captured instruction with OP=6'b111111 enters HALT on leaving DECODE; HALT holds halted=1, imem_req=0, instr_valid=0 and pc unchanged until reset.
REQ-033 Macro FETCH_HALT_EN undefined: HALT unreachable, OP=6'b111111 fetched as ordinary instruction, halted tied 0.

Structure
REQ-034 Shared package fetch_pkg SHALL hold the state enum, default RESET_PC, HALT_OP constant and OP/Funct/imm/target field bit positions.
REQ-035 Next-PC selection SHALL be a separate combinational sub-module next_pc_sel (inputs pc_plus4, instr, Branch, Zero, Jump; output next_pc).

Verification
REQ-036 Reset then ack in 1 cycle with rdata 32'h0000_0020 (add) -> imem_addr 0, instr_valid next cycle, OP=0, Funct=6'b100000, next fetch at 4.
REQ-037 pc=8, instr beq with imm 16'hFFFE, Branch=1, Zero=1 -> next imem_addr 4; same with Zero=0 -> 12.
REQ-038 pc=4, instr 32'h0800_0010, Jump=1 and Branch=1, Zero=1 -> next imem_addr 32'h0000_0040.
REQ-039 stall held 3 cycles in DECODE -> instr, pc and instr_valid unchanged, imem_req=0 throughout; advance on the cycle stall drops.
REQ-040 ack delayed 4 cycles, reset asserted in cycle 2 -> imem_req=0 during reset, pc=RESET_PC, new fetch starts after release.
REQ-041 With FETCH_HALT_EN, rdata 32'hFC00_0000 -> halted=1 after decode, no further imem_req; without the macro, fetch continues at pc+4.
